// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game constants and the enemy missile state type.
package game_pkg;

   localparam int          SCREEN_H      = 600;
   localparam int          PLAYER_W      = 64;
   localparam int          PLAYER_H      = 32;
   localparam logic [11:0] MISSILE_COLOR = 12'hF00;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_FLY  = 2'd1,
      MS_COOL = 2'd2
   } missile_state_e;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational test for two half-open rectangles intersecting.
module box_overlap (
   input  logic [10:0] a_x_i,
   input  logic [10:0] a_y_i,
   input  logic [10:0] a_w_i,
   input  logic [10:0] a_h_i,
   input  logic [10:0] b_x_i,
   input  logic [10:0] b_y_i,
   input  logic [10:0] b_w_i,
   input  logic [10:0] b_h_i,
   output logic        overlap_o
);

   // Far edges carry one extra bit so a box near 2047 cannot wrap.
   logic [11:0] a_r, a_b, b_r, b_b;

   assign a_r = {1'b0, a_x_i} + {1'b0, a_w_i};
   assign a_b = {1'b0, a_y_i} + {1'b0, a_h_i};
   assign b_r = {1'b0, b_x_i} + {1'b0, b_w_i};
   assign b_b = {1'b0, b_y_i} + {1'b0, b_h_i};

   assign overlap_o = ({1'b0, a_x_i} < b_r) && ({1'b0, b_x_i} < a_r) &&
                      ({1'b0, a_y_i} < b_b) && ({1'b0, b_y_i} < a_b);

endmodule

// File: rtl/enemy_missile.sv
// rtl/enemy_missile.sv - enemy missile launch/fly/cooldown FSM with one-cycle overlay render.
// Player collision is built only when ENEMY_MISSILE_COLLISION_EN is defined.
module enemy_missile #(
   parameter int          MISSILE_W = 4,
   parameter int          MISSILE_H = 12,
   parameter int          SPEED     = 4,
   parameter int          SCREEN_H  = game_pkg::SCREEN_H,
   parameter int          COOLDOWN  = 30,
   parameter int          PLAYER_W  = game_pkg::PLAYER_W,
   parameter int          PLAYER_H  = game_pkg::PLAYER_H,
   parameter logic [11:0] COLOR     = game_pkg::MISSILE_COLOR
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] vcount_in,
   input  logic [10:0] hcount_in,
   input  logic        vsync_in,
   input  logic        hsync_in,
   input  logic        vblnk_in,
   input  logic        hblnk_in,
   input  logic [11:0] rgb_in,
   input  logic [10:0] en_x_missile,
   input  logic [10:0] en_y_missile,
   input  logic        en_alive,
   input  logic [10:0] xpos_player,
   input  logic [10:0] ypos_player,
   output logic [10:0] vcount_out,
   output logic [10:0] hcount_out,
   output logic        vsync_out,
   output logic        hsync_out,
   output logic        vblnk_out,
   output logic        hblnk_out,
   output logic [11:0] rgb_out,
   output logic        hit,
   output logic        missile_active
);

   import game_pkg::*;

   localparam int          CNT_W     = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN);
   localparam logic [11:0] SPEED_C   = 12'(SPEED);
   localparam logic [11:0] SCREEN_C  = 12'(SCREEN_H);
   localparam logic [11:0] MW_C      = 12'(MISSILE_W);
   localparam logic [11:0] MH_C      = 12'(MISSILE_H);

   missile_state_e   state_q, state_d;
   logic [10:0]      x_q, x_d, y_q, y_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hit_q, hit_d;
   logic             vsync_prev_q;
   logic             frame_tick;
   logic             overlap;
   logic [11:0]      y_next;

   logic [10:0]      vcount_q, hcount_q;
   logic             vsync_q, hsync_q, vblnk_q, hblnk_q;
   logic [11:0]      rgb_q, rgb_d;
   logic             pix_on;

   assign frame_tick = vsync_in && !vsync_prev_q;
   assign y_next     = {1'b0, y_q} + SPEED_C;

`ifdef ENEMY_MISSILE_COLLISION_EN
   box_overlap u_player_hit (
      .a_x_i     (x_q),
      .a_y_i     (y_q),
      .a_w_i     (11'(MISSILE_W)),
      .a_h_i     (11'(MISSILE_H)),
      .b_x_i     (xpos_player),
      .b_y_i     (ypos_player),
      .b_w_i     (11'(PLAYER_W)),
      .b_h_i     (11'(PLAYER_H)),
      .overlap_o (overlap)
   );
`else
   logic unused_player;
   assign unused_player = ^{xpos_player, ypos_player};
   assign overlap       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      hit_d   = 1'b0;
      if (frame_tick) begin
         case (state_q)
            MS_IDLE: begin
               if (en_alive) begin
                  x_d     = en_x_missile;
                  y_d     = en_y_missile;
                  state_d = MS_FLY;
               end
            end
            MS_FLY: begin
               // Hit wins over a bottom exit on the same frame.
               if (overlap) begin
                  hit_d   = 1'b1;
                  state_d = MS_COOL;
                  cnt_d   = COOL_LOAD;
               end else if (y_next >= SCREEN_C) begin
                  state_d = MS_COOL;
                  cnt_d   = COOL_LOAD;
               end else begin
                  y_d = y_next[10:0];
               end
            end
            MS_COOL: begin
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = MS_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: state_d = MS_IDLE;
         endcase
      end
   end

   always_comb begin
      pix_on = (state_q == MS_FLY) &&
               ({1'b0, hcount_in} >= {1'b0, x_q}) && ({1'b0, hcount_in} < ({1'b0, x_q} + MW_C)) &&
               ({1'b0, vcount_in} >= {1'b0, y_q}) && ({1'b0, vcount_in} < ({1'b0, y_q} + MH_C)) &&
               ({1'b0, vcount_in} < SCREEN_C) && !hblnk_in && !vblnk_in;
      rgb_d  = pix_on ? COLOR : rgb_in;
   end

   always_ff @(posedge pclk) begin
      if (!rst) begin
         state_q      <= MS_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         cnt_q        <= '0;
         hit_q        <= 1'b0;
         vsync_prev_q <= 1'b0;
         vcount_q     <= '0;
         hcount_q     <= '0;
         vsync_q      <= 1'b0;
         hsync_q      <= 1'b0;
         vblnk_q      <= 1'b0;
         hblnk_q      <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         cnt_q        <= cnt_d;
         hit_q        <= hit_d;
         vsync_prev_q <= vsync_in;
         vcount_q     <= vcount_in;
         hcount_q     <= hcount_in;
         vsync_q      <= vsync_in;
         hsync_q      <= hsync_in;
         vblnk_q      <= vblnk_in;
         hblnk_q      <= hblnk_in;
         rgb_q        <= rgb_d;
      end
   end

   assign vcount_out     = vcount_q;
   assign hcount_out     = hcount_q;
   assign vsync_out      = vsync_q;
   assign hsync_out      = hsync_q;
   assign vblnk_out      = vblnk_q;
   assign hblnk_out      = hblnk_q;
   assign rgb_out        = rgb_q;
   assign hit            = hit_q;
   assign missile_active = (state_q == MS_FLY);

endmodule

// File: tb/tb_enemy_missile.sv
// tb/tb_enemy_missile.sv - self-checking bench for enemy_missile against a frame-level model.
module tb_enemy_missile;

`ifdef ENEMY_MISSILE_COLLISION_EN
   localparam bit COLL_EN = 1'b1;
`else
   localparam bit COLL_EN = 1'b0;
`endif

   logic        pclk = 1'b0;
   logic        rst;
   logic [10:0] vcount_in, hcount_in;
   logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
   logic [11:0] rgb_in;
   logic [10:0] en_x_missile, en_y_missile;
   logic        en_alive;
   logic [10:0] xpos_player, ypos_player;
   logic [10:0] vcount_out, hcount_out;
   logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
   logic [11:0] rgb_out;
   logic        hit, missile_active;

   always #5 pclk = ~pclk;

   enemy_missile dut (
      .pclk           (pclk),
      .rst            (rst),
      .vcount_in      (vcount_in),
      .hcount_in      (hcount_in),
      .vsync_in       (vsync_in),
      .hsync_in       (hsync_in),
      .vblnk_in       (vblnk_in),
      .hblnk_in       (hblnk_in),
      .rgb_in         (rgb_in),
      .en_x_missile   (en_x_missile),
      .en_y_missile   (en_y_missile),
      .en_alive       (en_alive),
      .xpos_player    (xpos_player),
      .ypos_player    (ypos_player),
      .vcount_out     (vcount_out),
      .hcount_out     (hcount_out),
      .vsync_out      (vsync_out),
      .hsync_out      (hsync_out),
      .vblnk_out      (vblnk_out),
      .hblnk_out      (hblnk_out),
      .rgb_out        (rgb_out),
      .hit            (hit),
      .missile_active (missile_active)
   );

   int checks   = 0;
   int failures = 0;

   // Frame-level model: 0 = waiting, 1 = flying, 2 = cooling down.
   int m_state, m_x, m_y, m_cnt;
   bit m_hit;
   int last_hit;

   typedef struct {
      int h; int v; bit hb; bit vb; int rgb; int exp;
   } pix_vec_t;
   pix_vec_t tbl[11];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   function automatic bit overlap_ref(input int x, input int y, input int xp, input int yp);
      return (x < xp + 64) && (xp < x + 4) && (y < yp + 32) && (yp < y + 12);
   endfunction

   function automatic bit lit_ref(input int h, input int v, input bit hb, input bit vb);
      return (m_state == 1) && (h >= m_x) && (h < m_x + 4) && (v >= m_y) && (v < m_y + 12) &&
             (v < 600) && !hb && !vb;
   endfunction

   task automatic model_reset();
      m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_hit = 1'b0;
   endtask

   task automatic model_tick();
      m_hit = 1'b0;
      if (m_state == 0) begin
         if (en_alive) begin
            m_x = int'(en_x_missile); m_y = int'(en_y_missile); m_state = 1;
         end
      end else if (m_state == 1) begin
         if (COLL_EN && overlap_ref(m_x, m_y, int'(xpos_player), int'(ypos_player))) begin
            m_hit = 1'b1; m_state = 2; m_cnt = 30;
         end else if (m_y + 4 >= 600) begin
            m_state = 2; m_cnt = 30;
         end else begin
            m_y = m_y + 4;
         end
      end else begin
         m_cnt = m_cnt - 1;
         if (m_cnt <= 0) begin
            m_state = 0; m_cnt = 0;
         end
      end
   endtask

   task automatic frame(input string tag);
      hcount_in = '0; vcount_in = '0; hblnk_in = 1'b1; vblnk_in = 1'b1;
      vsync_in  = 1'b1;
      model_tick();
      step();
      last_hit = int'(hit);
      check({tag, "_hit"}, int'(hit), int'(m_hit));
      check({tag, "_active"}, int'(missile_active), int'(m_state == 1));
      check({tag, "_vsync_out"}, int'(vsync_out), 1);
      vsync_in = 1'b0;
      step();
      check({tag, "_hit_clear"}, int'(hit), 0);
   endtask

   task automatic pixel(input string tag, input int h, input int v, input bit hb, input bit vb,
                        input int rgb, input int exp);
      hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = vb;
      rgb_in    = 12'(rgb);
      hsync_in  = 1'($urandom_range(0, 1));
      step();
      check({tag, "_rgb"}, int'(rgb_out), exp);
      check({tag, "_hcount"}, int'(hcount_out), h);
      check({tag, "_vcount"}, int'(vcount_out), v);
      check({tag, "_hsync"}, int'(hsync_out), int'(hsync_in));
      check({tag, "_blank"}, int'({hblnk_out, vblnk_out}), int'({hb, vb}));
   endtask

   task automatic pixel_model(input string tag, input int h, input int v, input bit hb,
                              input bit vb, input int rgb);
      pixel(tag, h, v, hb, vb, rgb, lit_ref(h, v, hb, vb) ? 'hF00 : rgb);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rgb"}, int'(rgb_out), 0);
      check({tag, "_counts"}, int'({vcount_out, hcount_out}), 0);
      check({tag, "_syncs"}, int'({vsync_out, hsync_out, vblnk_out, hblnk_out}), 0);
      check({tag, "_hit"}, int'(hit), 0);
      check({tag, "_active"}, int'(missile_active), 0);
   endtask

   task automatic drain_to_idle();
      for (int i = 0; i < 300 && m_state != 0; i++) frame("drain");
   endtask

   initial begin
      tbl[0]  = '{400, 104, 1'b0, 1'b0, 'h0AB, 'hF00};
      tbl[1]  = '{403, 104, 1'b0, 1'b0, 'h0AB, 'hF00};
      tbl[2]  = '{400, 115, 1'b0, 1'b0, 'h0AB, 'hF00};
      tbl[3]  = '{403, 115, 1'b0, 1'b0, 'h0AB, 'hF00};
      tbl[4]  = '{404, 104, 1'b0, 1'b0, 'h123, 'h123};
      tbl[5]  = '{399, 110, 1'b0, 1'b0, 'h456, 'h456};
      tbl[6]  = '{401, 103, 1'b0, 1'b0, 'h789, 'h789};
      tbl[7]  = '{401, 116, 1'b0, 1'b0, 'h111, 'h111};
      tbl[8]  = '{401, 110, 1'b1, 1'b0, 'h222, 'h222};
      tbl[9]  = '{402, 110, 1'b0, 1'b1, 'h333, 'h333};
      tbl[10] = '{402, 110, 1'b0, 1'b0, 'h444, 'hF00};

      rst = 1'b0;
      vcount_in = 11'd5; hcount_in = 11'd7; vsync_in = 1'b1; hsync_in = 1'b1;
      vblnk_in = 1'b1; hblnk_in = 1'b1; rgb_in = 12'hABC;
      en_x_missile = 11'd400; en_y_missile = 11'd100; en_alive = 1'b1;
      xpos_player = '0; ypos_player = '0;
      step(); step();
      check_outputs_zero("reset");
      model_reset();

      vsync_in = 1'b0; en_alive = 1'b0;
      rst = 1'b1;
      frame("idle_dead");

      en_alive = 1'b1;
      frame("launch");
      pixel("launch_top", 400, 100, 1'b0, 1'b0, 'h00F, 'hF00);
      pixel("launch_above", 400, 99, 1'b0, 1'b0, 'h00F, 'h00F);
      frame("fly1");
      foreach (tbl[i])
         pixel($sformatf("tbl%0d", i), tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb,
               tbl[i].rgb, tbl[i].exp);

      // en_alive low mid-flight must not disturb the missile.
      en_alive = 1'b0;
      for (int i = 0; i < 200 && m_state == 1; i++) begin
         if (m_y == 596) begin
            pixel("clip_last_row", 400, 599, 1'b0, 1'b0, 'h0F0, 'hF00);
            pixel("clip_off_screen", 400, 600, 1'b0, 1'b0, 'h0F0, 'h0F0);
         end
         frame("to_bottom");
      end

      en_alive = 1'b1;
      begin
         int n;
         n = 0;
         for (int i = 0; i < 40; i++) begin
            frame("cool");
            n++;
            if (missile_active) break;
         end
         check("relaunch_ticks", n, 31);
      end

      xpos_player = 11'd390; ypos_player = 11'd110;
      frame("hit");
      check("hit_pulse", last_hit, int'(COLL_EN));
      check("after_hit_active", int'(missile_active), int'(!COLL_EN));
      en_alive = 1'b0;
      drain_to_idle();

      en_alive = 1'b1; en_x_missile = 11'd400; en_y_missile = 11'd596;
      xpos_player = 11'd390; ypos_player = 11'd590;
      frame("simul_launch");
      en_alive = 1'b0;
      frame("simul");
      check("simul_hit", last_hit, int'(COLL_EN));
      check("simul_active", int'(missile_active), 0);
      drain_to_idle();

      en_alive = 1'b1; en_x_missile = 11'd100; en_y_missile = 11'd200;
      xpos_player = '0; ypos_player = '0;
      frame("rst_launch");
      frame("rst_fly");
      rst = 1'b0; hsync_in = 1'b1;
      step();
      check_outputs_zero("midflight_reset");
      model_reset();
      rst = 1'b1; en_alive = 1'b0;
      frame("rst_release_dead");
      frame("rst_release_dead2");

      for (int f = 0; f < 400; f++) begin
         en_alive     = ($urandom_range(0, 3) != 0);
         en_x_missile = 11'($urandom_range(0, 800));
         en_y_missile = 11'($urandom_range(0, 640));
         if ($urandom_range(0, 1) == 1) begin
            xpos_player = 11'((m_x > 70) ? m_x - int'($urandom_range(0, 70)) : int'($urandom_range(0, 80)));
            ypos_player = 11'((m_y > 40) ? m_y - int'($urandom_range(0, 40)) : int'($urandom_range(0, 50)));
         end else begin
            xpos_player = 11'($urandom_range(0, 800));
            ypos_player = 11'($urandom_range(0, 600));
         end
         frame("rand");
         for (int p = 0; p < 3; p++) begin
            int h, v;
            h = m_x + int'($urandom_range(0, 8)) - 2;
            v = m_y + int'($urandom_range(0, 16)) - 2;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
            pixel_model("rand_pix", h, v, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                        int'($urandom_range(0, 4095)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
